// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered, parametrised ALU with persistent carry/zero flags,
//           a valid/ready input handshake and an iterative shift-add
//           unsigned multiplier.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   operation request
//   in_ready   operation can be accepted this cycle (IDLE and not in reset)
//   a, b       WIDTH-bit operands
//   op         4-bit opcode
//   y          registered result
//   c_flag     registered carry / borrow flag
//   z_flag     registered zero flag
//   out_valid  one-cycle pulse when y/flags were updated by a completed op
//   busy       multiply in progress
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             c_flag,
    output logic             z_flag,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [3:0] OP_PASSA = 4'd0;
    localparam logic [3:0] OP_CMP   = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_NAND  = 4'd4;
    localparam logic [3:0] OP_ADC   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;

    localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                 state_r;
    logic [2*WIDTH-1:0]     mcand_r;
    logic [2*WIDTH-1:0]     acc_r;
    logic [2*WIDTH-1:0]     acc_next_s;
    logic [WIDTH-1:0]       mplier_r;
    logic [4:0]             cnt_r;

    logic [WIDTH:0]         sum_s;
    logic [WIDTH:0]         diff_s;
    logic [WIDTH-1:0]       res_s;
    logic                   carry_s;
    logic                   zero_s;
    logic                   wr_y_s;
    logic                   accept_s;

    // Handshake: ready only while idle and out of reset.
    assign in_ready = rst_n & (state_r == ST_IDLE);
    assign accept_s = in_valid & in_ready;

    // Single-cycle datapath evaluated from the live inputs and current c_flag,
    // so the values latched at the accepting edge are the captured ones.
    always_comb begin
        sum_s   = {1'b0, a} + {1'b0, b}
                + {{WIDTH{1'b0}}, ((op == OP_ADC) ? c_flag : 1'b0)};
        diff_s  = {1'b0, a} - {1'b0, b};
        res_s   = '0;
        carry_s = 1'b0;
        wr_y_s  = 1'b1;
        case (op)
            OP_PASSA: res_s = a;
            OP_CMP: begin
                // Difference drives the flags only; y keeps its old value.
                res_s   = diff_s[WIDTH-1:0];
                carry_s = diff_s[WIDTH];
                wr_y_s  = 1'b0;
            end
            OP_PASSB: res_s = b;
            OP_ADD, OP_ADC: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
            end
            OP_NAND: res_s = ~(a & b);
            OP_SUB: begin
                res_s   = diff_s[WIDTH-1:0];
                carry_s = diff_s[WIDTH];
            end
            OP_XOR: res_s = a ^ b;
            OP_SHL: begin
                res_s   = {a[WIDTH-2:0], 1'b0};
                carry_s = a[WIDTH-1];
            end
            OP_SHR: begin
                res_s   = {1'b0, a[WIDTH-1:1]};
                carry_s = a[0];
            end
            default: begin
                res_s   = '0;
                carry_s = 1'b0;
            end
        endcase
        // For CMP the difference is zero exactly when a == b, so one rule fits all.
        zero_s = (res_s == '0);
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM, multiplier registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            y         <= '0;
            c_flag    <= 1'b0;
            z_flag    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            mcand_r   <= '0;
            acc_r     <= '0;
            mplier_r  <= '0;
            cnt_r     <= 5'd0;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (op == OP_MUL) begin
                            state_r  <= ST_MUL;
                            busy     <= 1'b1;
                            acc_r    <= '0;
                            mcand_r  <= {{WIDTH{1'b0}}, a};
                            mplier_r <= b;
                            cnt_r    <= 5'd0;
                        end else begin
                            if (wr_y_s) begin
                                y <= res_s;
                            end
                            c_flag    <= carry_s;
                            z_flag    <= zero_s;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + 5'd1;
                    // Last multiplier bit: acc_next_s holds the full product.
                    if (cnt_r == LAST_STEP) begin
                        y         <= acc_next_s[WIDTH-1:0];
                        c_flag    <= |acc_next_s[2*WIDTH-1:WIDTH];
                        z_flag    <= (acc_next_s[WIDTH-1:0] == '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq at WIDTH=4 and WIDTH=8.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] y;
    logic       c_flag;
    logic       z_flag;
    logic       out_valid;
    logic       busy;

    logic       in_valid8;
    logic       in_ready8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [3:0] op8;
    logic [7:0] y8;
    logic       c_flag8;
    logic       z_flag8;
    logic       out_valid8;
    logic       busy8;

    int errors;
    int checks;

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .y(y), .c_flag(c_flag), .z_flag(z_flag),
        .out_valid(out_valid), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .y(y8), .c_flag(c_flag8), .z_flag(z_flag8),
        .out_valid(out_valid8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request on the 4-bit DUT and sample just after the next edge.
    task automatic issue(input logic [3:0] o, input logic [3:0] va, input logic [3:0] vb);
        @(negedge clk);
        op = o; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; op = 4'd3; a = 4'd9; b = 4'd8;
        in_valid8 = 1'b0; op8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (y !== 4'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
        checks++; if (c_flag !== 1'b0) begin errors++; $display("FAIL reset_c: got %0b expected 0", c_flag); end
        checks++; if (z_flag !== 1'b0) begin errors++; $display("FAIL reset_z: got %0b expected 0", z_flag); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_add_adc();
        issue(4'd3, 4'd9, 4'd8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_ov: got %0b expected 1", out_valid); end
        checks++; if (y !== 4'd1) begin errors++; $display("FAIL add_y: got %0d expected 1", y); end
        checks++; if (c_flag !== 1'b1) begin errors++; $display("FAIL add_c: got %0b expected 1", c_flag); end
        checks++; if (z_flag !== 1'b0) begin errors++; $display("FAIL add_z: got %0b expected 0", z_flag); end
        issue(4'd5, 4'd0, 4'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL adc_ov: got %0b expected 1", out_valid); end
        checks++; if (y !== 4'd1) begin errors++; $display("FAIL adc_y: got %0d expected 1", y); end
        checks++; if (c_flag !== 1'b0) begin errors++; $display("FAIL adc_c: got %0b expected 0", c_flag); end
        checks++; if (z_flag !== 1'b0) begin errors++; $display("FAIL adc_z: got %0b expected 0", z_flag); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_ov: got %0b expected 0", out_valid); end
        checks++; if (y !== 4'd1) begin errors++; $display("FAIL idle_hold_y: got %0d expected 1", y); end
    endtask

    task automatic test_cmp_sub();
        issue(4'd0, 4'd5, 4'd0);
        checks++; if (y !== 4'd5) begin errors++; $display("FAIL passa_y: got %0d expected 5", y); end
        issue(4'd1, 4'd3, 4'd7);
        checks++; if (y !== 4'd5) begin errors++; $display("FAIL cmp_lt_y: got %0d expected 5", y); end
        checks++; if (c_flag !== 1'b1) begin errors++; $display("FAIL cmp_lt_c: got %0b expected 1", c_flag); end
        checks++; if (z_flag !== 1'b0) begin errors++; $display("FAIL cmp_lt_z: got %0b expected 0", z_flag); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cmp_lt_ov: got %0b expected 1", out_valid); end
        issue(4'd1, 4'd6, 4'd6);
        checks++; if (y !== 4'd5) begin errors++; $display("FAIL cmp_eq_y: got %0d expected 5", y); end
        checks++; if (c_flag !== 1'b0) begin errors++; $display("FAIL cmp_eq_c: got %0b expected 0", c_flag); end
        checks++; if (z_flag !== 1'b1) begin errors++; $display("FAIL cmp_eq_z: got %0b expected 1", z_flag); end
        issue(4'd6, 4'd3, 4'd7);
        checks++; if (y !== 4'd12) begin errors++; $display("FAIL sub_y: got %0d expected 12", y); end
        checks++; if (c_flag !== 1'b1) begin errors++; $display("FAIL sub_c: got %0b expected 1", c_flag); end
        checks++; if (z_flag !== 1'b0) begin errors++; $display("FAIL sub_z: got %0b expected 0", z_flag); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_mul();
        logic [3:0] ma [2];
        logic [3:0] mb [2];
        logic [3:0] ey [2];
        logic       ec [2];
        logic       ez [2];
        ma[0] = 4'd7;  mb[0] = 4'd3; ey[0] = 4'd5; ec[0] = 1'b1; ez[0] = 1'b0;
        ma[1] = 4'd15; mb[1] = 4'd0; ey[1] = 4'd0; ec[1] = 1'b0; ez[1] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            issue(4'd10, ma[v], mb[v]);
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL mul%0d_accept: got busy=%0b ready=%0b ov=%0b expected 1 0 0", v, busy, in_ready, out_valid);
            end
            @(negedge clk);
            in_valid = 1'b0;
            for (int e = 1; e <= 4; e++) begin
                @(posedge clk); #1;
                if (e < 4) begin
                    checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                        errors++; $display("FAIL mul%0d_edge%0d: got busy=%0b ready=%0b ov=%0b expected 1 0 0", v, e, busy, in_ready, out_valid);
                    end
                end else begin
                    checks++; if (out_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
                        errors++; $display("FAIL mul%0d_done: got ov=%0b busy=%0b ready=%0b expected 1 0 1", v, out_valid, busy, in_ready);
                    end
                    checks++; if (y !== ey[v] || c_flag !== ec[v] || z_flag !== ez[v]) begin
                        errors++; $display("FAIL mul%0d_result: got y=%0d c=%0b z=%0b expected y=%0d c=%0b z=%0b", v, y, c_flag, z_flag, ey[v], ec[v], ez[v]);
                    end
                end
            end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul%0d_pulse: got %0b expected 0", v, out_valid); end
        end
    endtask

    task automatic test_busy_reset();
        issue(4'd10, 4'd2, 4'd3);
        // Request PASSA 9 while busy and keep holding it.
        @(negedge clk);
        op = 4'd0; a = 4'd9; b = 4'd0; in_valid = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL busy_ov_e%0d: got %0b expected 0", e, out_valid); end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || y !== 4'd6) begin
            errors++; $display("FAIL busy_mul_done: got ov=%0b y=%0d expected 1 6", out_valid, y);
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || y !== 4'd9) begin
            errors++; $display("FAIL busy_held_accept: got ov=%0b y=%0d expected 1 9", out_valid, y);
        end
        // Mid-multiply reset on the second MUL edge.
        issue(4'd10, 4'd7, 4'd3);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (y !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            errors++; $display("FAIL midreset_state: got y=%0d busy=%0b ov=%0b c=%0b z=%0b expected 0 0 0 0 0", y, busy, out_valid, c_flag, z_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL midreset_idle_%0d: got ov=%0b busy=%0b ready=%0b expected 0 0 1", e, out_valid, busy, in_ready);
            end
        end
    endtask

    task automatic test_shift_logic();
        issue(4'd8, 4'd9, 4'd0);
        checks++; if (y !== 4'd2 || c_flag !== 1'b1 || z_flag !== 1'b0) begin
            errors++; $display("FAIL shl: got y=%0d c=%0b z=%0b expected 2 1 0", y, c_flag, z_flag);
        end
        issue(4'd9, 4'd1, 4'd0);
        checks++; if (y !== 4'd0 || c_flag !== 1'b1 || z_flag !== 1'b1) begin
            errors++; $display("FAIL shr: got y=%0d c=%0b z=%0b expected 0 1 1", y, c_flag, z_flag);
        end
        issue(4'd7, 4'd5, 4'd3);
        checks++; if (y !== 4'd6 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            errors++; $display("FAIL xor: got y=%0d c=%0b z=%0b expected 6 0 0", y, c_flag, z_flag);
        end
        issue(4'd4, 4'd15, 4'd15);
        checks++; if (y !== 4'd0 || c_flag !== 1'b0 || z_flag !== 1'b1) begin
            errors++; $display("FAIL nand: got y=%0d c=%0b z=%0b expected 0 0 1", y, c_flag, z_flag);
        end
        issue(4'd2, 4'd1, 4'd10);
        checks++; if (y !== 4'd10 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
            errors++; $display("FAIL passb: got y=%0d c=%0b z=%0b expected 10 0 0", y, c_flag, z_flag);
        end
        issue(4'd13, 4'd15, 4'd15);
        checks++; if (y !== 4'd0 || c_flag !== 1'b0 || z_flag !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL undef_op: got y=%0d c=%0b z=%0b ov=%0b expected 0 0 1 1", y, c_flag, z_flag, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_width8();
        int lat;
        @(negedge clk);
        op8 = 4'd3; a8 = 8'd200; b8 = 8'd100; in_valid8 = 1'b1;
        @(posedge clk); #1;
        checks++; if (y8 !== 8'd44 || c_flag8 !== 1'b1 || z_flag8 !== 1'b0 || out_valid8 !== 1'b1) begin
            errors++; $display("FAIL add8: got y=%0d c=%0b z=%0b ov=%0b expected 44 1 0 1", y8, c_flag8, z_flag8, out_valid8);
        end
        @(negedge clk);
        op8 = 4'd10; a8 = 8'd20; b8 = 8'd13;
        @(posedge clk); #1;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL mul8_latency: got %0d expected 8", lat); end
        checks++; if (y8 !== 8'd4 || c_flag8 !== 1'b1 || z_flag8 !== 1'b0) begin
            errors++; $display("FAIL mul8_result: got y=%0d c=%0b z=%0b expected 4 1 0", y8, c_flag8, z_flag8);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add_adc();
        test_cmp_sub();
        test_mul();
        test_busy_reset();
        test_shift_logic();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
